// File: rtl/huff_pkg.sv
// Shared constants and state encoding for the Huffman tree-build engine.
package huff_pkg;
   localparam int unsigned NSYM = 8;
   localparam int unsigned WW   = 16;
   localparam int unsigned SW   = WW + $clog2(NSYM);
   localparam int unsigned NN   = 2 * NSYM - 1;
   localparam int unsigned LW   = $clog2(NSYM);
   localparam int unsigned NW   = $clog2(NN);

   typedef enum logic [1:0] {IDLE, SCAN, MERGE, DONE} state_t;
endpackage

// File: rtl/huff_min2_tracker.sv
// Tracks the two lowest-weight nodes seen in a serial scan; ties keep the earlier node.
module huff_min2_tracker
   import huff_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          node_valid,
   input  logic [NW-1:0] node_idx,
   input  logic [SW-1:0] node_weight,
   output logic [NW-1:0] min1_idx,
   output logic [NW-1:0] min2_idx,
   output logic [SW-1:0] min1_weight,
   output logic [SW-1:0] min2_weight
);

   logic min1_valid;
   logic min2_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min1_idx    <= '0;
         min2_idx    <= '0;
         min1_weight <= '0;
         min2_weight <= '0;
         min1_valid  <= 1'b0;
         min2_valid  <= 1'b0;
      end else if (clear) begin
         min1_valid <= 1'b0;
         min2_valid <= 1'b0;
      end else if (node_valid) begin
         if (!min1_valid || (node_weight < min1_weight)) begin
            min2_idx    <= min1_idx;
            min2_weight <= min1_weight;
            min2_valid  <= min1_valid;
            min1_idx    <= node_idx;
            min1_weight <= node_weight;
            min1_valid  <= 1'b1;
         end else if (!min2_valid || (node_weight < min2_weight)) begin
            min2_idx    <= node_idx;
            min2_weight <= node_weight;
            min2_valid  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/huff_tree_sched.sv
// Tree-build sequencer: serial two-minimum scan per round, then parent creation,
// until the root exists. Node table is readable combinationally.
module huff_tree_sched
   import huff_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_en,
   input  logic [LW-1:0] ld_idx,
   input  logic [WW-1:0] ld_weight,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic [NW-1:0] rd_idx,
   output logic [NW-1:0] rd_parent,
   output logic          rd_bit,
   output logic [SW-1:0] rd_weight
);

   state_t        state;
   state_t        state_d;
   logic          busy_d;
   logic          done_d;
   logic [NW-1:0] idx;
   logic [NW-1:0] cnt;
   logic          scan_last;

   logic [SW-1:0] weight [NN];
   logic          active [NN];
   logic [NW-1:0] parent [NN];
   logic          branch [NN];

   logic [NW-1:0] min1_idx;
   logic [NW-1:0] min2_idx;
   logic [SW-1:0] min1_weight;
   logic [SW-1:0] min2_weight;
   logic          trk_clear;
   logic          trk_valid;

   assign scan_last = (idx == (cnt - NW'(1)));
   assign trk_clear = ((state == IDLE) && start) || (state == MERGE);
   assign trk_valid = (state == SCAN) && active[idx];

   huff_min2_tracker u_min2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (trk_clear),
      .node_valid  (trk_valid),
      .node_idx    (idx),
      .node_weight (weight[idx]),
      .min1_idx    (min1_idx),
      .min2_idx    (min2_idx),
      .min1_weight (min1_weight),
      .min2_weight (min2_weight)
   );

   // State and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (scan_last) state_d = MERGE;
         MERGE:   state_d = (cnt == NW'(NN - 1)) ? DONE : SCAN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status follows the state being entered so it lines up with the state register
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // Node table, scan index and node count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         cnt <= '0;
         for (int unsigned i = 0; i < NN; i++) begin
            weight[i] <= '0;
            active[i] <= 1'b0;
            parent[i] <= '0;
            branch[i] <= 1'b0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (ld_en) weight[ld_idx] <= SW'(ld_weight);
               if (start) begin
                  for (int unsigned i = 0; i < NN; i++) active[i] <= (i < NSYM);
                  cnt <= NW'(NSYM);
                  idx <= '0;
               end
            end
            SCAN: idx <= idx + NW'(1);
            MERGE: begin
               weight[cnt]      <= min1_weight + min2_weight;
               active[cnt]      <= 1'b1;
               active[min1_idx] <= 1'b0;
               active[min2_idx] <= 1'b0;
               parent[min1_idx] <= cnt;
               parent[min2_idx] <= cnt;
               branch[min1_idx] <= 1'b0;
               branch[min2_idx] <= 1'b1;
               if (cnt == NW'(NN - 1)) parent[cnt] <= cnt;
               cnt <= cnt + NW'(1);
               idx <= '0;
            end
            default: ;
         endcase
      end
   end

   // Combinational read port; out-of-range indices read as zero
   always_comb begin
      rd_parent = '0;
      rd_bit    = 1'b0;
      rd_weight = '0;
      if (rd_idx < NW'(NN)) begin
         rd_parent = parent[rd_idx];
         rd_bit    = branch[rd_idx];
         rd_weight = weight[rd_idx];
      end
   end

endmodule

// File: doc/huff_tree_sched.md
# huff_tree_sched

Sequencer for the tree-build phase of the Huffman coding engine. After the main control FSM has loaded the leaf weights (symbol frequencies), it runs NSYM-1 merge rounds. Each round scans the node array serially for the two lowest-weight active nodes and creates their parent. The resulting parent/bit table feeds the downstream code generator through a read port.

## Interface

Parameters:
- NSYM, 8: number of leaf symbols (≥2); total nodes NN = 2*NSYM-1
- WW, 16: leaf weight width; internal sum width SW = WW + $clog2(NSYM)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_en  in  1  write ld_weight into leaf ld_idx; honoured only when busy=0
- ld_idx  in  $clog2(NSYM)  leaf index
- ld_weight  in  WW  leaf weight
- start  in  1  begin tree build; honoured only when busy=0
- busy  out  1  high from cycle after accepted start until DONE cycle inclusive
- done  out  1  one-cycle pulse, tree complete
- rd_idx  in  $clog2(NN)  node to read
- rd_parent  out  $clog2(NN)  parent index of rd_idx; root returns itself
- rd_bit  out  1  branch bit of rd_idx toward parent (0 = smaller child)
- rd_weight  out  SW  weight of rd_idx

## Operation

- Storage: weight[NN] (SW bits), active[NN], parent[NN], bit[NN]; node count cnt.
- Reset: weights, parents, bits and active cleared to 0; cnt=0; state IDLE; busy=0, done=0.
- IDLE: ld_en writes the zero-extended weight. start sets active[0..NSYM-1]=1, all other active=0, cnt=NSYM, idx=0, min1/min2 invalid → SCAN. When ld_en and start occur together, the load is performed and start uses the new weight.
- SCAN: one node per cycle at idx. Skip the node if active=0. If weight < min1, then min2←min1 and min1←node. Else if weight < min2 (or min2 invalid), min2←node. Strict compares break ties toward lower index. After idx=cnt-1 → MERGE.
- MERGE: weight[cnt]=w(min1)+w(min2) with no overflow by sizing; active[cnt]=1. parent[min1]=parent[min2]=cnt; bit[min1]=0, bit[min2]=1. Clear active on both children. cnt++.
  - If cnt was NN-1 (root created): parent[root]=root → DONE.
  - Otherwise idx=0, mins invalid → SCAN.
- DONE: done=1 for one cycle → IDLE.
- Zero weights are legal and merge like any other value. Every leaf always receives a code.
- start, ld_en ignored while busy. Reads are combinational and always allowed; contents are defined only when busy=0.
- rst_n asserted mid-build aborts immediately to reset state. No partial tree remains.

## Timing

- Round k (k=0..NSYM-2) costs NSYM+k SCAN cycles + 1 MERGE cycle.
- NSYM=8: start sampled at edge E0; busy high from E0; DONE state (done=1) between E84 and E85; busy falls at E85. General: done at E(sum_k(NSYM+k+1)).
- Read path: zero-cycle combinational from rd_idx.
- Writes (load, merge) visible on the read port the cycle after the edge.

## Structure

- huff_pkg: NSYM, WW, SW, NN, index widths, state enum {IDLE, SCAN, MERGE, DONE}. Shared with the main control FSM and the code generator.
- Sub-module huff_min2_tracker: registered min1/min2 index, weight and valid. Inputs clear, node_valid, node_idx, node_weight. Holds the strict-less update rule.

## Test plan

- All weights 1: node8←(0,1), 9←(2,3), 10←(4,5), 11←(6,7), 12←(8,9) w4, 13←(10,11), 14←(12,13) w8. parent[14]=14. done at E84.
- Weights 1,2,4,8,16,32,64,128: node8=w3 from (0 bit0,1 bit1). Node9=w7 with parent[8]=9 bit0, parent[2]=9 bit1. Root weight 255.
- All weights 0: same topology as the all-ones case (lower-index tie-break). All internal weights 0.
- Weights max (2^16-1) ×8: root weight 8*(2^16-1) = 524280, no wrap in SW=19.
- ld_en/start pulsed during busy: weights and timing unchanged, done still at E84.
- rst_n low at E40: busy=0, done=0, all rd_weight=0 asynchronously. New start then completes normally.
